// File: rtl/toy_mem_arb_pkg.sv
// Shared types and defaults for the RISC_TOY unified-memory arbiter.
// Holds the FSM state encoding, the port-select encoding and the default sizes.
package toy_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_CAPT = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 32;
    localparam int DEF_WAIT = 0;

endpackage

// File: rtl/toy_mem_arb_if.sv
// Core-side instruction/data ports plus the SRAM pins of the unified-memory arbiter.
// Handshake: a requester raises IREQ/DREQ with address (and write data) stable and keeps it
// high until the one-cycle IRDY/DRDY pulse, then drops it in the following cycle.
interface toy_mem_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          IREQ;
    logic [29:0]   IADDR;
    logic [DW-1:0] INSTR;
    logic          IRDY;

    logic          DREQ;
    logic          DRW;
    logic [29:0]   DADDR;
    logic [DW-1:0] DWDATA;
    logic [DW-1:0] DRDATA;
    logic          DRDY;

    logic          MCSN;
    logic          MWEN;
    logic [AW-1:0] MA;
    logic [DW-1:0] MDI;
    logic [DW-1:0] MDOUT;

    modport slave (
        input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MDOUT,
        output INSTR, IRDY, DRDATA, DRDY, MCSN, MWEN, MA, MDI
    );

    modport master (
        output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MDOUT,
        input  INSTR, IRDY, DRDATA, DRDY, MCSN, MWEN, MA, MDI
    );

endinterface

// File: rtl/toy_mem_arb_rr_arb2.sv
// Two-requester arbiter: fixed data priority or round-robin on conflict.
// The last-grant register starts at "data", so the first round-robin conflict favours instruction.
module toy_rr_arb2
    import toy_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rr,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_update,
    output logic o_grant
);
    logic r_last;

    always_comb begin
        o_grant = PORT_I;
        if (i_req_i && i_req_d)
            o_grant = i_rr ? ~r_last : PORT_D;
        else if (i_req_d)
            o_grant = PORT_D;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= PORT_D;
        else if (i_update)
            r_last <= o_grant;
    end

endmodule

// File: rtl/toy_mem_arb.sv
// Unified-memory arbiter: merges instruction fetch and data ports onto one single-port SRAM
// with a fixed per-access sequence IDLE -> CMD -> CAPT -> (WAIT) -> DONE.
module toy_mem_arb
    import toy_mem_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int WAIT = DEF_WAIT,
    parameter int RR   = 0
) (
    input  logic          CLK,
    input  logic          RST,
    toy_mem_arb_if.slave  bus,
    output state_t        o_dbg_state
);
    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t        r_state;
    state_t        w_next;
    logic          r_port;
    logic          r_we;
    logic [3:0]    r_cnt;
    logic          r_mcsn;
    logic          r_mwen;
    logic [AW-1:0] r_ma;
    logic [DW-1:0] r_mdi;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_drdata;

    logic w_any_req;
    logic w_take;
    logic w_grant;
    logic w_grant_wr;

    assign w_any_req  = bus.IREQ || bus.DREQ;
    assign w_take     = (r_state == ST_IDLE) && w_any_req;
    assign w_grant_wr = (w_grant == PORT_D) && bus.DRW;

    toy_rr_arb2 u_arb (
        .clk      (CLK),
        .rst      (RST),
        .i_rr     (RR != 0),
        .i_req_i  (bus.IREQ),
        .i_req_d  (bus.DREQ),
        .i_update (w_take),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next = ST_CMD;
            ST_CMD:  w_next = ST_CAPT;
            ST_CAPT: w_next = (WAIT > 0) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobe pins are loaded on the grant edge so they are registered yet active during CMD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_port   <= PORT_I;
            r_we     <= 1'b0;
            r_cnt    <= 4'd0;
            r_mcsn   <= 1'b1;
            r_mwen   <= 1'b1;
            r_ma     <= '0;
            r_mdi    <= '0;
            r_instr  <= '0;
            r_drdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port <= w_grant;
                        r_we   <= w_grant_wr;
                        r_mcsn <= 1'b0;
                        r_mwen <= ~w_grant_wr;
                        r_ma   <= (w_grant == PORT_D) ? bus.DADDR[AW+1:2] : bus.IADDR[AW+1:2];
                        if (w_grant == PORT_D)
                            r_mdi <= bus.DWDATA;
                    end
                end
                ST_CMD: begin
                    r_mcsn <= 1'b1;
                    r_mwen <= 1'b1;
                end
                ST_CAPT: begin
                    if (r_port == PORT_I)
                        r_instr <= bus.MDOUT;
                    else if (!r_we)
                        r_drdata <= bus.MDOUT;
                    if (WAIT > 0)
                        r_cnt <= WAIT_M1;
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.MCSN   = r_mcsn;
    assign bus.MWEN   = r_mwen;
    assign bus.MA     = r_ma;
    assign bus.MDI    = r_mdi;
    assign bus.INSTR  = r_instr;
    assign bus.DRDATA = r_drdata;
    assign bus.IRDY   = (r_state == ST_DONE) && (r_port == PORT_I);
    assign bus.DRDY   = (r_state == ST_DONE) && (r_port == PORT_D);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_toy_mem_arb.sv
// Directed bench for toy_mem_arb: three instances (WAIT=0/RR=0, WAIT=0/RR=1, WAIT=3/RR=0),
// each with its own SRAM model preloaded with word i = 0xA5A50000|i and word 5 = 0xDEADBEEF.
module tb_toy_mem_arb;
  import toy_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ireq [3];
  logic        dreq [3];
  logic        drw [3];
  logic [29:0] iaddr [3];
  logic [29:0] daddr [3];
  logic [31:0] dwdata [3];
  logic [31:0] instr [3];
  logic [31:0] drdata [3];
  logic [31:0] mdi [3];
  logic        irdy [3];
  logic        drdy [3];
  logic        mcsn [3];
  logic        mwen [3];
  logic [9:0]  ma [3];
  state_t      st [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int WT  = (k == 2) ? 3 : 0;
    localparam int RRV = (k == 1) ? 1 : 0;
    toy_mem_arb_if #(.AW(10), .DW(32)) bus ();
    logic [31:0] mem [1024];
    logic [31:0] mdout_r;
    state_t      dbg;

    toy_mem_arb #(.AW(10), .DW(32), .WAIT(WT), .RR(RRV)) dut (
      .CLK         (clk),
      .RST         (rst),
      .bus         (bus),
      .o_dbg_state (dbg)
    );

    assign bus.IREQ   = ireq[k];
    assign bus.IADDR  = iaddr[k];
    assign bus.DREQ   = dreq[k];
    assign bus.DRW    = drw[k];
    assign bus.DADDR  = daddr[k];
    assign bus.DWDATA = dwdata[k];
    assign bus.MDOUT  = mdout_r;
    assign instr[k]   = bus.INSTR;
    assign drdata[k]  = bus.DRDATA;
    assign irdy[k]    = bus.IRDY;
    assign drdy[k]    = bus.DRDY;
    assign mcsn[k]    = bus.MCSN;
    assign mwen[k]    = bus.MWEN;
    assign ma[k]      = bus.MA;
    assign mdi[k]     = bus.MDI;
    assign st[k]      = dbg;

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      mem[5] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
      if (!bus.MCSN) begin
        if (!bus.MWEN) mem[bus.MA] <= bus.MDI;
        mdout_r <= mem[bus.MA];
      end
    end
  end

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts at cycle 0 of an IDLE slot; returns at the IDLE cycle after RDY with the request dropped.
  task automatic do_access(input int k, input bit d, input bit rw, input logic [29:0] a,
                           input logic [31:0] wd, output int t_s, output int t_r,
                           output logic [9:0] ma_s, output logic mwen_s, output logic [31:0] mdi_s);
    t_s = -1; t_r = -1; ma_s = '0; mwen_s = 1'b1; mdi_s = '0;
    if (d) begin
      dreq[k] = 1'b1; drw[k] = rw; daddr[k] = a; dwdata[k] = wd;
    end else begin
      ireq[k] = 1'b1; iaddr[k] = a;
    end
    for (int c = 0; c < 40 && t_r < 0; c++) begin
      if (mcsn[k] === 1'b0 && t_s < 0) begin
        t_s = c; ma_s = ma[k]; mwen_s = mwen[k]; mdi_s = mdi[k];
      end
      if ((d ? drdy[k] : irdy[k]) === 1'b1) t_r = c;
      next_cyc();
    end
    ireq[k] = 1'b0; dreq[k] = 1'b0; drw[k] = 1'b0;
  endtask

  task automatic run_conflict(input int k, output int t_i, output int t_d);
    t_i = -1; t_d = -1;
    ireq[k] = 1'b1; iaddr[k] = 30'h14;
    dreq[k] = 1'b1; drw[k] = 1'b0; daddr[k] = 30'h18;
    for (int c = 0; c < 40 && (t_i < 0 || t_d < 0); c++) begin
      if (irdy[k] === 1'b1) t_i = c;
      if (drdy[k] === 1'b1) t_d = c;
      next_cyc();
      if (t_i >= 0) ireq[k] = 1'b0;
      if (t_d >= 0) dreq[k] = 1'b0;
    end
    ireq[k] = 1'b0; dreq[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (st[k] !== ST_IDLE) begin n_err++; $display("FAIL reset_state[%0d]: got %0d want %0d", k, st[k], ST_IDLE); end
      n_cmp++; if (mcsn[k] !== 1'b1) begin n_err++; $display("FAIL reset_mcsn[%0d]: got %b want 1", k, mcsn[k]); end
      n_cmp++; if (mwen[k] !== 1'b1) begin n_err++; $display("FAIL reset_mwen[%0d]: got %b want 1", k, mwen[k]); end
      n_cmp++; if (ma[k] !== 10'h0) begin n_err++; $display("FAIL reset_ma[%0d]: got %h want 0", k, ma[k]); end
      n_cmp++; if (mdi[k] !== 32'h0) begin n_err++; $display("FAIL reset_mdi[%0d]: got %h want 0", k, mdi[k]); end
      n_cmp++; if ({irdy[k], drdy[k]} !== 2'b00) begin n_err++; $display("FAIL reset_rdy[%0d]: got %b%b want 00", k, irdy[k], drdy[k]); end
      n_cmp++; if (instr[k] !== 32'h0) begin n_err++; $display("FAIL reset_instr[%0d]: got %h want 0", k, instr[k]); end
      n_cmp++; if (drdata[k] !== 32'h0) begin n_err++; $display("FAIL reset_drdata[%0d]: got %h want 0", k, drdata[k]); end
    end
  endtask

  task automatic test_single_read();
    int ts, tr; logic [9:0] mas; logic mw; logic [31:0] md;
    do_access(0, 1'b0, 1'b0, 30'h14, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (ts !== 1) begin n_err++; $display("FAIL rd_strobe_cycle: got %0d want 1", ts); end
    n_cmp++; if (mas !== 10'd5) begin n_err++; $display("FAIL rd_ma: got %h want 005", mas); end
    n_cmp++; if (mw !== 1'b1) begin n_err++; $display("FAIL rd_mwen: got %b want 1", mw); end
    n_cmp++; if (tr !== 3) begin n_err++; $display("FAIL rd_irdy_cycle: got %0d want 3", tr); end
    n_cmp++; if (instr[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_instr: got %h want deadbeef", instr[0]); end
    n_cmp++; if (drdata[0] !== 32'h0) begin n_err++; $display("FAIL rd_drdata_untouched: got %h want 0", drdata[0]); end
  endtask

  task automatic test_write_read();
    int ts, tr; logic [9:0] mas; logic mw; logic [31:0] md;
    do_access(0, 1'b1, 1'b1, 30'h40, 32'h1234_5678, ts, tr, mas, mw, md);
    n_cmp++; if (ts !== 1) begin n_err++; $display("FAIL wr_strobe_cycle: got %0d want 1", ts); end
    n_cmp++; if (mw !== 1'b0) begin n_err++; $display("FAIL wr_mwen: got %b want 0", mw); end
    n_cmp++; if (mas !== 10'h010) begin n_err++; $display("FAIL wr_ma: got %h want 010", mas); end
    n_cmp++; if (md !== 32'h1234_5678) begin n_err++; $display("FAIL wr_mdi: got %h want 12345678", md); end
    n_cmp++; if (tr !== 3) begin n_err++; $display("FAIL wr_drdy_cycle: got %0d want 3", tr); end
    n_cmp++; if (drdata[0] !== 32'h0) begin n_err++; $display("FAIL wr_drdata_unchanged: got %h want 0", drdata[0]); end
    do_access(0, 1'b1, 1'b0, 30'h40, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (tr !== 3) begin n_err++; $display("FAIL rdback_drdy_cycle: got %0d want 3", tr); end
    n_cmp++; if (drdata[0] !== 32'h1234_5678) begin n_err++; $display("FAIL rdback_drdata: got %h want 12345678", drdata[0]); end
    n_cmp++; if (instr[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdback_instr_kept: got %h want deadbeef", instr[0]); end
  endtask

  task automatic test_conflict();
    int ti, td;
    run_conflict(0, ti, td);
    n_cmp++; if (td !== 3) begin n_err++; $display("FAIL fix_drdy_cycle: got %0d want 3", td); end
    n_cmp++; if (ti !== 7) begin n_err++; $display("FAIL fix_irdy_cycle: got %0d want 7", ti); end
    run_conflict(1, ti, td);
    n_cmp++; if (ti !== 3) begin n_err++; $display("FAIL rr1_irdy_cycle: got %0d want 3", ti); end
    n_cmp++; if (td !== 7) begin n_err++; $display("FAIL rr1_drdy_cycle: got %0d want 7", td); end
    n_cmp++; if (instr[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rr1_instr: got %h want deadbeef", instr[1]); end
    n_cmp++; if (drdata[1] !== pat(6)) begin n_err++; $display("FAIL rr1_drdata: got %h want %h", drdata[1], pat(6)); end
    run_conflict(1, ti, td);
    n_cmp++; if (ti !== 3) begin n_err++; $display("FAIL rr2_irdy_cycle: got %0d want 3", ti); end
    n_cmp++; if (td !== 7) begin n_err++; $display("FAIL rr2_drdy_cycle: got %0d want 7", td); end
  endtask

  task automatic test_wait_states();
    int ts, tr, s0, s1, nrdy, consec; logic [9:0] mas; logic mw; logic [31:0] md; logic prev;
    do_access(2, 1'b1, 1'b0, 30'h1C, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (ts !== 1) begin n_err++; $display("FAIL w3_strobe_cycle: got %0d want 1", ts); end
    n_cmp++; if (tr !== 6) begin n_err++; $display("FAIL w3_drdy_cycle: got %0d want 6", tr); end
    n_cmp++; if (drdata[2] !== pat(7)) begin n_err++; $display("FAIL w3_drdata: got %h want %h", drdata[2], pat(7)); end
    s0 = -1; s1 = -1; nrdy = 0; consec = 0; prev = 1'b1;
    ireq[2] = 1'b1; iaddr[2] = 30'h20;
    for (int c = 0; c < 20; c++) begin
      if (mcsn[2] === 1'b0) begin
        if (s0 < 0) s0 = c; else if (s1 < 0) s1 = c;
        if (prev === 1'b0) consec++;
      end
      prev = mcsn[2];
      if (irdy[2] === 1'b1) nrdy++;
      next_cyc();
    end
    ireq[2] = 1'b0;
    repeat (10) next_cyc();
    n_cmp++; if (s0 !== 1) begin n_err++; $display("FAIL b2b_first_strobe: got %0d want 1", s0); end
    n_cmp++; if (s1 - s0 !== 7) begin n_err++; $display("FAIL b2b_strobe_gap: got %0d want 7", s1 - s0); end
    n_cmp++; if (consec !== 0) begin n_err++; $display("FAIL b2b_consec_strobe: got %0d want 0", consec); end
    n_cmp++; if (nrdy !== 2) begin n_err++; $display("FAIL b2b_irdy_count: got %0d want 2", nrdy); end
    n_cmp++; if (instr[2] !== pat(8)) begin n_err++; $display("FAIL b2b_instr: got %h want %h", instr[2], pat(8)); end
  endtask

  task automatic test_alias();
    int ts, tr; logic [9:0] mas; logic mw; logic [31:0] md;
    do_access(0, 1'b1, 1'b0, 30'h1014, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (mas !== 10'd5) begin n_err++; $display("FAIL alias_ma: got %h want 005", mas); end
    n_cmp++; if (drdata[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alias_drdata: got %h want deadbeef", drdata[0]); end
    do_access(0, 1'b1, 1'b1, 30'h2000_0024, 32'hCAFE_F00D, ts, tr, mas, mw, md);
    n_cmp++; if (mas !== 10'd9) begin n_err++; $display("FAIL alias_wr_ma: got %h want 009", mas); end
    do_access(0, 1'b0, 1'b0, 30'h24, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (instr[0] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL alias_rdback: got %h want cafef00d", instr[0]); end
  endtask

  task automatic test_reset_mid();
    int ts, tr, nrdy; logic [9:0] mas; logic mw; logic [31:0] md;
    dreq[0] = 1'b1; drw[0] = 1'b0; daddr[0] = 30'h1C;
    next_cyc();
    n_cmp++; if (mcsn[0] !== 1'b0) begin n_err++; $display("FAIL rm_strobe: got %b want 0", mcsn[0]); end
    next_cyc();
    n_cmp++; if (st[0] !== ST_CAPT) begin n_err++; $display("FAIL rm_in_capt: got %0d want %0d", st[0], ST_CAPT); end
    rst = 1'b1; dreq[0] = 1'b0;
    next_cyc();
    rst = 1'b0;
    n_cmp++; if (st[0] !== ST_IDLE) begin n_err++; $display("FAIL rm_state: got %0d want %0d", st[0], ST_IDLE); end
    n_cmp++; if ({mcsn[0], mwen[0]} !== 2'b11) begin n_err++; $display("FAIL rm_strobes: got %b%b want 11", mcsn[0], mwen[0]); end
    n_cmp++; if (ma[0] !== 10'h0 || mdi[0] !== 32'h0) begin n_err++; $display("FAIL rm_ma_mdi: got %h/%h want 0/0", ma[0], mdi[0]); end
    n_cmp++; if (instr[0] !== 32'h0 || drdata[0] !== 32'h0) begin n_err++; $display("FAIL rm_data: got %h/%h want 0/0", instr[0], drdata[0]); end
    nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      if (irdy[0] === 1'b1 || drdy[0] === 1'b1) nrdy++;
      next_cyc();
    end
    n_cmp++; if (nrdy !== 0) begin n_err++; $display("FAIL rm_no_rdy: got %0d pulses want 0", nrdy); end
    do_access(0, 1'b0, 1'b0, 30'h14, 32'h0, ts, tr, mas, mw, md);
    n_cmp++; if (tr !== 3) begin n_err++; $display("FAIL rm_after_irdy_cycle: got %0d want 3", tr); end
    n_cmp++; if (instr[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rm_after_instr: got %h want deadbeef", instr[0]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ireq[k] = 1'b0; dreq[k] = 1'b0; drw[k] = 1'b0;
      iaddr[k] = '0; daddr[k] = '0; dwdata[k] = '0;
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_conflict();
    test_wait_states();
    test_alias();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
